turn_timer: RTL and testbench

Per-turn countdown timer for the Connect 4 game, counting whole seconds in BCD from a preset down to 00. It sits directly upstream of two `seven_segment` decoders: `tens` drives one decoder's `i` and `ones` drives the other. The game controller starts it on every turn change and consumes `timeout` to forfeit or auto-drop the current move.

---
 rtl/turn_timer.sv | 121 ++++++++++++
 tb/tb_turn_timer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/turn_timer.sv
// Per-turn BCD countdown timer: reloads TURN_SECS on start, ticks once per CLK_HZ
// cycles, and pulses timeout for one cycle when the count reaches 00.
module turn_timer #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TURN_SECS = 30,
  parameter int unsigned WARN_SECS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       warn,
  output logic       timeout
);

  localparam int unsigned PW        = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);
  localparam logic [3:0] TENS_INIT  = 4'(TURN_SECS / 10);
  localparam logic [3:0] ONES_INIT  = 4'(TURN_SECS % 10);
  localparam logic [6:0] WARN_VAL   = 7'(WARN_SECS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          running_q, running_d;
  logic          warn_q, warn_d;
  logic          timeout_q, timeout_d;
  logic [6:0]    value_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      running_q <= 1'b0;
      warn_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      running_q <= running_d;
      warn_q    <= warn_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state: clear beats start beats the prescaler tick
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    timeout_d = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      presc_d = '0;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
    end else if (start) begin
      state_d = ST_RUN;
      presc_d = '0;
      tens_d  = TENS_INIT;
      ones_d  = ONES_INIT;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!pause) begin
            if (presc_q == PRESC_TC) begin
              presc_d = '0;
              if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
              end else begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
              end
              if (tens_q == 4'd0 && ones_q == 4'd1) begin
                state_d   = ST_EXPIRED;
                timeout_d = 1'b1;
              end
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end
        ST_IDLE, ST_EXPIRED: presc_d = '0;
        default: begin
          state_d = ST_IDLE;
          presc_d = '0;
        end
      endcase
    end

    // warn is derived from next-state digits so it lines up with them
    value_d   = 7'(tens_d) * 7'd10 + 7'(ones_d);
    running_d = (state_d == ST_RUN);
    warn_d    = running_d && (value_d != 7'd0) && (value_d <= WARN_VAL);
  end

  assign tens    = tens_q;
  assign ones    = ones_q;
  assign running = running_q;
  assign warn    = warn_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_turn_timer.sv
// Directed bench for turn_timer: vector table for the main countdown scenarios plus
// hand-written collision, reset and maximum-preset sequences.
module tb_turn_timer;

  typedef struct {
    logic       rst;
    logic       start;
    logic       pause;
    logic       clear;
    int         n;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       run;
    logic       warn;
    logic       to;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, start_a, pause_a, clear_a, start_b, pause_b, clear_b;
  logic [3:0] tens_a, ones_a, tens_b, ones_b;
  logic       run_a, warn_a, to_a, run_b, warn_b, to_b;

  int n_checks = 0;
  int n_fail   = 0;
  int to_cnt_a = 0;
  int to_cnt_b = 0;

  turn_timer #(.CLK_HZ(4), .TURN_SECS(12), .WARN_SECS(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pause(pause_a), .clear(clear_a),
    .tens(tens_a), .ones(ones_a), .running(run_a), .warn(warn_a), .timeout(to_a)
  );

  turn_timer #(.CLK_HZ(2), .TURN_SECS(99), .WARN_SECS(5)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pause(pause_b), .clear(clear_b),
    .tens(tens_b), .ones(ones_b), .running(run_b), .warn(warn_b), .timeout(to_b)
  );

  always #5 clk = ~clk;

  // Count timeout-high cycles, sampled mid-cycle
  always @(negedge clk) begin
    if (to_a === 1'b1) to_cnt_a++;
    if (to_b === 1'b1) to_cnt_b++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_n(input int n);
    repeat (n) step();
  endtask

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got tens=%0d ones=%0d run=%b warn=%b to=%b, expected tens=%0d ones=%0d run=%b warn=%b to=%b",
               name, got[10:7], got[6:3], got[2], got[1], got[0],
               exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [10:0] out_a();
    return {tens_a, ones_a, run_a, warn_a, to_a};
  endfunction

  function automatic logic [10:0] ex(input logic [3:0] t, input logic [3:0] o,
                                     input logic r, input logic w, input logic to);
    return {t, o, r, w, to};
  endfunction

  function automatic vec_t mk(input logic r, input logic s, input logic p, input logic c,
                              input int n, input logic [3:0] t, input logic [3:0] o,
                              input logic ru, input logic w, input logic to);
    vec_t v;
    v.rst = r; v.start = s; v.pause = p; v.clear = c; v.n = n;
    v.tens = t; v.ones = o; v.run = ru; v.warn = w; v.to = to;
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    int   snap;
    int   v;
    logic digits_ok;

    rst = 1'b0; start_a = 1'b0; pause_a = 1'b0; clear_a = 1'b0;
    start_b = 1'b0; pause_b = 1'b0; clear_b = 1'b0;

    // Reset, full countdown, pause, restart mid-count (edge numbers relative to start)
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1,  4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1,  4'd1, 4'd2, 1'b1, 1'b0, 1'b0)); // e0
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 4,  4'd1, 4'd1, 1'b1, 1'b0, 1'b0)); // e4
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8,  4'd0, 4'd9, 1'b1, 1'b0, 1'b0)); // e12
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 23, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0)); // e35
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1,  4'd0, 4'd3, 1'b1, 1'b1, 1'b0)); // e36
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 11, 4'd0, 4'd1, 1'b1, 1'b1, 1'b0)); // e47
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1,  4'd0, 4'd0, 1'b0, 1'b0, 1'b1)); // e48
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1,  4'd0, 4'd0, 1'b0, 1'b0, 1'b0)); // e49
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 4,  4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1,  4'd1, 4'd2, 1'b1, 1'b0, 1'b0)); // e0
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1,  4'd1, 4'd2, 1'b1, 1'b0, 1'b0)); // e1
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 10, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0)); // e11
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2,  4'd1, 4'd2, 1'b1, 1'b0, 1'b0)); // e13
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1,  4'd1, 4'd1, 1'b1, 1'b0, 1'b0)); // e14
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 43, 4'd0, 4'd1, 1'b1, 1'b1, 1'b0)); // e57
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1,  4'd0, 4'd0, 1'b0, 1'b0, 1'b1)); // e58
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1,  4'd1, 4'd2, 1'b1, 1'b0, 1'b0)); // e0
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 7,  4'd1, 4'd1, 1'b1, 1'b0, 1'b0)); // e7
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1,  4'd1, 4'd2, 1'b1, 1'b0, 1'b0)); // e8
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 3,  4'd1, 4'd2, 1'b1, 1'b0, 1'b0)); // e11
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1,  4'd1, 4'd1, 1'b1, 1'b0, 1'b0)); // e12
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 43, 4'd0, 4'd1, 1'b1, 1'b1, 1'b0)); // e55
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1,  4'd0, 4'd0, 1'b0, 1'b0, 1'b1)); // e56
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1,  4'd0, 4'd0, 1'b0, 1'b0, 1'b0)); // e57

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; start_a = vecs[i].start; clear_a = vecs[i].clear;
      pause_a = vecs[i].pause;
      step();
      rst = 1'b0; start_a = 1'b0; clear_a = 1'b0;
      run_n(vecs[i].n - 1);
      pause_a = 1'b0;
      check($sformatf("vec%0d", i), out_a(),
            ex(vecs[i].tens, vecs[i].ones, vecs[i].run, vecs[i].warn, vecs[i].to));
    end
    step();
    check_int("timeout_pulses_table", to_cnt_a, 3);
    check_int("dut_b_idle_after_reset", {28'd0, tens_b} * 10 + {28'd0, ones_b} + {31'd0, run_b}, 0);

    // start coincident with the tick at edge 4
    start_a = 1'b1; step(); start_a = 1'b0;
    run_n(3);
    start_a = 1'b1; step(); start_a = 1'b0;
    check("start_on_tick_e4", out_a(), ex(4'd1, 4'd2, 1'b1, 1'b0, 1'b0));
    run_n(3);
    check("start_on_tick_e7", out_a(), ex(4'd1, 4'd2, 1'b1, 1'b0, 1'b0));
    step();
    check("start_on_tick_e8", out_a(), ex(4'd1, 4'd1, 1'b1, 1'b0, 1'b0));

    // clear coincident with the 01 -> 00 tick
    snap = to_cnt_a;
    start_a = 1'b1; step(); start_a = 1'b0;
    run_n(47);
    check("clear_tick_e47", out_a(), ex(4'd0, 4'd1, 1'b1, 1'b1, 1'b0));
    clear_a = 1'b1; step(); clear_a = 1'b0;
    check("clear_tick_e48", out_a(), ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    pause_a = 1'b1; run_n(3); pause_a = 1'b0;
    check("clear_tick_idle", out_a(), ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    check_int("clear_tick_no_timeout", to_cnt_a - snap, 0);

    // synchronous reset mid-count, then restart
    snap = to_cnt_a;
    start_a = 1'b1; step(); start_a = 1'b0;
    run_n(19);
    check("reset_pre_e19", out_a(), ex(4'd0, 4'd8, 1'b1, 1'b0, 1'b0));
    rst = 1'b1; step(); rst = 1'b0;
    check("reset_e20", out_a(), ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    step();
    check("reset_e21", out_a(), ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    start_a = 1'b1; step(); start_a = 1'b0;
    check("reset_restart_e22", out_a(), ex(4'd1, 4'd2, 1'b1, 1'b0, 1'b0));
    run_n(3);
    check("reset_restart_e25", out_a(), ex(4'd1, 4'd2, 1'b1, 1'b0, 1'b0));
    step();
    check("reset_restart_e26", out_a(), ex(4'd1, 4'd1, 1'b1, 1'b0, 1'b0));
    check_int("reset_no_timeout", to_cnt_a - snap, 0);
    clear_a = 1'b1; step(); clear_a = 1'b0;

    // maximum preset on dut_b: value after edge k is 99 - k/2
    digits_ok = 1'b1;
    snap = to_cnt_b;
    start_b = 1'b1; step(); start_b = 1'b0;
    for (int k = 0; k <= 199; k++) begin
      if (k > 0) step();
      v = (k >= 198) ? 0 : 99 - k / 2;
      if (tens_b > 4'd9 || ones_b > 4'd9) digits_ok = 1'b0;
      check($sformatf("max_preset_k%0d", k), {tens_b, ones_b, run_b, warn_b, to_b},
            ex(4'(v / 10), 4'(v % 10), v != 0, (v != 0) && (v <= 5), k == 198));
    end
    check_int("max_preset_digits_in_range", int'(digits_ok), 1);
    step();
    check_int("max_preset_timeout_pulses", to_cnt_b - snap, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
